countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Sequencing controller for the lab timebase: gates a programmable prescaler and drives a 2-digit BCD countdown from it.
- Handles start/pause/clear/load user commands through a 4-state FSM.
- Outputs a one-cycle tick, the BCD digits, and status flags for the display and LED blocks downstream.
- Inputs are single-cycle pulses from the existing debounce/one-pulse blocks.

Parameters:
- TICK_CYCLES, 50000000, clk cycles per countdown step (0.5 s at 100 MHz); minimum legal value 2.
- CNT_WIDTH, 27, prescaler width; must hold TICK_CYCLES-1.
- INIT_VAL, 8'h30, BCD reload value {tens, ones}.

Ports:
- clk  input  1  global clock
- rst  input  1  asynchronous reset, active-high
- start_pause  input  1  one-cycle pulse; toggles between run and pause
- clear  input  1  one-cycle pulse; abort and reload
- load_en  input  1  one-cycle pulse; capture load_val
- load_val  input  8  BCD value {tens[7:4], ones[3:0]}
- tick  output  1  one-cycle pulse per decrement
- bcd_tens  output  4  current tens digit
- bcd_ones  output  4  current ones digit
- running  output  1  high in RUN
- done  output  1  high in DONE
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, {bcd_tens,bcd_ones}=INIT_VAL, reload register=INIT_VAL, prescaler=0.
  - tick=0, running=0, done=0.
  - All outputs are registered.
- Reset mid-operation: same values, applied immediately, regardless of state.
- Command priority in one cycle: clear > load_en > start_pause.
- Prescaler:
  - Counts only in RUN.
  - At value TICK_CYCLES-1 it wraps to 0 on the next edge; call this the wrap edge.
  - Holds its value in PAUSE, so resume continues mid-period.
  - Forced to 0 in IDLE and DONE.
- Wrap edge in RUN:
  - count decrements in BCD: ones 0 -> 9 with tens-1; otherwise ones-1.
  - tick=1 for exactly the following cycle, coincident with the new count.
  - If the new count is 00: state -> DONE on the same edge; tick still pulses.
- FSM transitions:
  - IDLE:
    - start_pause with count != 00 -> RUN.
    - start_pause with count == 00 -> stay IDLE.
    - load_en -> reload register and count = sanitized load_val, stay IDLE.
  - RUN:
    - start_pause -> PAUSE.
    - Wrap edge to 00 -> DONE.
    - load_en ignored.
  - PAUSE:
    - start_pause -> RUN.
    - load_en ignored.
  - DONE:
    - start_pause and load_en ignored.
    - Count holds 00; done=1.
  - Any state: clear -> IDLE, count = reload register, prescaler=0, tick=0.
- Sanitizing load_val: any digit > 9 is clamped to 9 (e.g. 8'hA7 -> 8'h97, 8'h3F -> 8'h39).
- start_pause on a wrap edge in RUN:
  - Pause wins; the decrement and tick are suppressed.
  - Prescaler holds at TICK_CYCLES-1, so the first RUN edge after resume is the wrap edge.
- clear on a wrap edge: clear wins; no tick, no decrement.
- running = (state==RUN); done = (state==DONE); both registered with state.
- Latency from a start_pause pulse in IDLE to the first tick: exactly TICK_CYCLES+1 cycles (state changes on edge 1; prescaler wraps TICK_CYCLES edges later; tick is visible in the following cycle).

Test Plan (TICK_CYCLES=4, INIT_VAL=8'h03):
- Reset then start_pause pulse -> running=1 next cycle; ticks every 4 cycles; count 03 -> 02 -> 01 -> 00; state=DONE and done=1 together with the third tick; prescaler stays 0 afterwards.
- Load 8'h10 in IDLE, then run -> after the first tick count = 09 (BCD borrow); tick period stays 4 cycles.
- Run, pulse start_pause 2 cycles into a period, wait 20 cycles, pulse again -> no ticks and no count change while paused; next tick arrives 2 cycles after resume.
- start_pause pulse exactly on a wrap edge -> no tick, count unchanged, state=PAUSE; after resume, tick on the first RUN edge.
- clear in RUN, PAUSE and DONE, including on a wrap edge -> state=IDLE, count=reload value (03, or the last loaded value), no tick, running=0, done=0.
- load_val=8'hAF in IDLE -> count=99; load_en in RUN -> ignored; rst asserted mid-RUN -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/countdown_ctrl_if.sv
// Command/status bundle between the user-input front end and countdown_ctrl.
// Commands are single-cycle pulses; status lines are registered in the controller.
interface countdown_ctrl_if;
    logic       start_pause;
    logic       clear;
    logic       load_en;
    logic [7:0] load_val;
    logic       tick;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       done;
    logic [1:0] state;

    modport master (
        output start_pause, clear, load_en, load_val,
        input  tick, bcd_tens, bcd_ones, running, done, state
    );

    modport slave (
        input  start_pause, clear, load_en, load_val,
        output tick, bcd_tens, bcd_ones, running, done, state
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Lab timebase sequencer: prescaler-gated 2-digit BCD countdown with
// start/pause/clear/load command handling. All outputs are registered.
module countdown_ctrl #(
    parameter int         TICK_CYCLES = 50000000,
    parameter int         CNT_WIDTH   = 27,
    parameter logic [7:0] INIT_VAL    = 8'h30
) (
    input  logic            clk,
    input  logic            rst,
    countdown_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_WIDTH-1:0] PRE_MAX = CNT_WIDTH'(TICK_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] pre_q, pre_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           reload_q, reload_d;
    logic [7:0]           dec_val, load_san;
    logic                 tick_q, tick_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 wrap, step_ok;

    assign wrap    = (state_q == RUN) && (pre_q == PRE_MAX);
    // pause and clear both take precedence over a decrement on the wrap edge
    assign step_ok = wrap && !bus.start_pause && !bus.clear;

    always_comb begin
        dec_val = cnt_q;
        if (cnt_q[3:0] == 4'd0)
            dec_val = {cnt_q[7:4] - 4'd1, 4'd9};
        else
            dec_val = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
    end

    always_comb begin
        load_san[7:4] = (bus.load_val[7:4] > 4'd9) ? 4'd9 : bus.load_val[7:4];
        load_san[3:0] = (bus.load_val[3:0] > 4'd9) ? 4'd9 : bus.load_val[3:0];
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (!bus.load_en && bus.start_pause && cnt_q != 8'h00) state_d = RUN;
                RUN: begin
                    if (bus.start_pause)                    state_d = PAUSE;
                    else if (step_ok && dec_val == 8'h00)   state_d = DONE;
                end
                PAUSE: if (bus.start_pause) state_d = RUN;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // output / datapath next values
    always_comb begin
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        tick_d    = step_ok;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        pre_d     = pre_q;
        if (bus.clear) begin
            cnt_d = reload_q;
            pre_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pre_d = '0;
                    if (bus.load_en) begin
                        cnt_d    = load_san;
                        reload_d = load_san;
                    end
                end
                RUN: begin
                    if (!bus.start_pause) begin
                        pre_d = wrap ? '0 : pre_q + CNT_WIDTH'(1);
                        if (step_ok) cnt_d = dec_val;
                    end
                end
                PAUSE:   pre_d = pre_q;
                default: pre_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            cnt_q    <= INIT_VAL;
            reload_q <= INIT_VAL;
            tick_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.bcd_tens = cnt_q[7:4];
    assign bus.bcd_ones = cnt_q[3:0];
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a short prescale period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_ctrl;
    logic clk, rst;
    int   nvec, nerr;

    countdown_ctrl_if cif();

    countdown_ctrl #(.TICK_CYCLES(4), .CNT_WIDTH(4), .INIT_VAL(8'h03)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic sp, input logic cl, input logic ld);
        cif.start_pause = sp;
        cif.clear       = cl;
        cif.load_en     = ld;
        @(negedge clk);
        cif.start_pause = 1'b0;
        cif.clear       = 1'b0;
        cif.load_en     = 1'b0;
    endtask

    task automatic quiet(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            ticks += int'(cif.tick);
        end
    endtask

    function automatic logic [7:0] cnt();
        return {cif.bcd_tens, cif.bcd_ones};
    endfunction

    logic [7:0] ld_in [3];
    logic [7:0] ld_exp[3];
    int         nt;

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1;
        cif.start_pause = 1'b0; cif.clear = 1'b0; cif.load_en = 1'b0; cif.load_val = 8'h00;
        ld_in  = '{8'hA7, 8'h3F, 8'hAF};
        ld_exp = '{8'h97, 8'h39, 8'h99};
        step(2);
        chk("rst_state", cif.state, 0);
        chk("rst_cnt", cnt(), 8'h03);
        chk("rst_flags", {cif.tick, cif.running, cif.done}, 0);
        rst = 1'b0;
        step(1);

        // full countdown 03 -> 00
        pulse(1, 0, 0);
        chk("start_run", {cif.running, cif.state}, {1'b1, 2'd1});
        step(3);
        chk("pre_tick1", {cif.tick, cnt()}, {1'b0, 8'h03});
        step(1);
        chk("tick1", {cif.tick, cnt()}, {1'b1, 8'h02});
        step(1);
        chk("tick1_end", cif.tick, 0);
        step(3);
        chk("tick2", {cif.tick, cnt()}, {1'b1, 8'h01});
        step(4);
        chk("tick3_done", {cif.tick, cnt(), cif.state, cif.done, cif.running},
            {1'b1, 8'h00, 2'd3, 1'b1, 1'b0});
        quiet(10, nt);
        chk("done_quiet", {nt[7:0], cnt(), cif.state}, {8'd0, 8'h00, 2'd3});
        pulse(1, 0, 1);
        chk("done_ignore", cif.state, 3);
        pulse(0, 1, 0);
        chk("clr_done", {cif.state, cnt(), cif.done}, {2'd0, 8'h03, 1'b0});

        // load 10, BCD borrow
        cif.load_val = 8'h10;
        pulse(0, 0, 1);
        chk("load10", {cif.state, cnt()}, {2'd0, 8'h10});
        pulse(1, 0, 0);
        step(4);
        chk("borrow", {cif.tick, cnt()}, {1'b1, 8'h09});
        step(4);
        chk("period4", {cif.tick, cnt()}, {1'b1, 8'h08});
        pulse(0, 1, 0);
        chk("clr_run", {cif.state, cnt(), cif.tick, cif.running}, {2'd0, 8'h10, 1'b0, 1'b0});

        // pause two cycles into a period
        pulse(1, 0, 0);
        step(2);
        pulse(1, 0, 0);
        chk("paused", {cif.state, cif.running}, {2'd2, 1'b0});
        quiet(20, nt);
        chk("pause_quiet", {nt[7:0], cnt()}, {8'd0, 8'h10});
        pulse(1, 0, 0);
        chk("resume", {cif.state, cif.tick}, {2'd1, 1'b0});
        step(1);
        chk("resume_wait", cif.tick, 0);
        step(1);
        chk("resume_tick", {cif.tick, cnt()}, {1'b1, 8'h09});

        // pause exactly on the wrap edge
        step(3);
        pulse(1, 0, 0);
        chk("wrap_pause", {cif.tick, cnt(), cif.state}, {1'b0, 8'h09, 2'd2});
        pulse(1, 0, 0);
        chk("wrap_resume", {cif.tick, cif.state}, {1'b0, 2'd1});
        step(1);
        chk("wrap_first", {cif.tick, cnt()}, {1'b1, 8'h08});

        // clear on the wrap edge, then clear from PAUSE
        step(3);
        pulse(0, 1, 0);
        chk("clr_wrap", {cif.state, cnt(), cif.tick}, {2'd0, 8'h10, 1'b0});
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("pause2", cif.state, 2);
        pulse(0, 1, 0);
        chk("clr_pause", {cif.state, cnt(), cif.running}, {2'd0, 8'h10, 1'b0});

        // zero count cannot start; sanitized loads
        cif.load_val = 8'h00;
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        chk("zero_nostart", {cif.state, cnt()}, {2'd0, 8'h00});
        for (int i = 0; i < 3; i++) begin
            cif.load_val = ld_in[i];
            pulse(0, 0, 1);
            chk($sformatf("load_%h", ld_in[i]), cnt(), ld_exp[i]);
        end
        cif.load_val = 8'h55;
        pulse(0, 1, 1);
        chk("prio_clr_ld", {cif.state, cnt()}, {2'd0, 8'h99});
        pulse(1, 0, 1);
        chk("prio_ld_sp", {cif.state, cnt()}, {2'd0, 8'h55});
        cif.load_val = 8'hAF;
        pulse(0, 0, 1);
        chk("load_AF", cnt(), 8'h99);

        // load ignored in RUN, async reset mid-run
        pulse(1, 0, 0);
        cif.load_val = 8'h22;
        pulse(0, 0, 1);
        chk("run_ld_ign", {cif.state, cnt()}, {2'd1, 8'h99});
        step(6);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {cif.state, cnt(), cif.tick, cif.running, cif.done},
            {2'd0, 8'h03, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        pulse(0, 1, 0);
        chk("rst_reload", {cif.state, cnt()}, {2'd0, 8'h03});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
